mult_cpa_pipe: RTL and testbench

- Pipelined carry-propagate adder directly downstream of the carry-save multiplier mult_cs.
- Consumes the redundant sum/carry pair and produces the final binary product, which is (sum + carry) mod 2^(2*WIDTH).
- The 2*WIDTH-bit addition is split into CHUNK-bit slices, one slice per pipeline stage, so the ripple carry never crosses more than CHUNK bits per cycle.
- Valid/ready handshake on both sides; the whole pipeline stalls under backpressure.

---
 rtl/mult_cpa_pipe_if.sv | 25 ++
 rtl/mult_cpa_pipe.sv | 85 ++++++++
 tb/tb_mult_cpa_pipe.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_cpa_pipe_if.sv
// Handshake bundle between the carry-save multiplier output and the final adder pipeline.
// master drives operands and out_ready; slave is the adder pipeline.
interface mult_cpa_pipe_if #(
    parameter int WIDTH = 16
);
    localparam int DW = 2 * WIDTH;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_sum;
    logic [DW-1:0] in_carry;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_product;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_product
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_product
    );
endinterface

// File: rtl/mult_cpa_pipe.sv
// Pipelined carry-propagate adder that resolves a carry-save sum/carry pair into a binary
// product, adding one CHUNK-bit slice per stage and stalling the whole pipe on backpressure.
module mult_cpa_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    mult_cpa_pipe_if.slave  bus
);
    localparam int DW      = 2 * WIDTH;
    localparam int NSTAGES = DW / CHUNK;
    localparam logic [DW-1:0] SLICE_MASK = DW'({CHUNK{1'b1}});

    // Stage registers; index k is the register at the end of stage k.
    logic          valid_reg [NSTAGES];
    logic [DW-1:0] sum_reg   [NSTAGES];
    logic [DW-1:0] carry_reg [NSTAGES];
    logic [DW-1:0] res_reg   [NSTAGES];
    logic          cout_reg  [NSTAGES];

    // Combinational view of what each stage sees from its predecessor.
    logic          src_valid [NSTAGES];
    logic [DW-1:0] src_sum   [NSTAGES];
    logic [DW-1:0] src_carry [NSTAGES];
    logic [DW-1:0] src_res   [NSTAGES];
    logic          src_cin   [NSTAGES];
    logic [CHUNK:0] add_w    [NSTAGES];
    logic [DW-1:0] res_next  [NSTAGES];

    logic stall;

    assign stall           = valid_reg[NSTAGES-1] & ~bus.out_ready;
    assign bus.in_ready    = ~stall;
    assign bus.out_valid   = valid_reg[NSTAGES-1];
    assign bus.out_product = res_reg[NSTAGES-1];

    generate
        for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
            localparam int LO = gi * CHUNK;

            if (gi == 0) begin : g_head
                assign src_valid[gi] = bus.in_valid;
                assign src_sum[gi]   = bus.in_sum;
                assign src_carry[gi] = bus.in_carry;
                assign src_res[gi]   = '0;
                assign src_cin[gi]   = 1'b0;
            end else begin : g_body
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_sum[gi]   = sum_reg[gi-1];
                assign src_carry[gi] = carry_reg[gi-1];
                assign src_res[gi]   = res_reg[gi-1];
                assign src_cin[gi]   = cout_reg[gi-1];
            end

            // The top stage's carry-out lands in cout_reg but is never consumed (mod 2^DW).
            assign add_w[gi] = {1'b0, src_sum[gi][LO +: CHUNK]}
                             + {1'b0, src_carry[gi][LO +: CHUNK]}
                             + (CHUNK + 1)'(src_cin[gi]);

            assign res_next[gi] = (src_res[gi] & ~(SLICE_MASK << LO))
                                | (DW'(add_w[gi][CHUNK-1:0]) << LO);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSTAGES; k++) begin
                valid_reg[k] <= 1'b0;
                sum_reg[k]   <= '0;
                carry_reg[k] <= '0;
                res_reg[k]   <= '0;
                cout_reg[k]  <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < NSTAGES; k++) begin
                valid_reg[k] <= src_valid[k];
                sum_reg[k]   <= src_sum[k];
                carry_reg[k] <= src_carry[k];
                res_reg[k]   <= res_next[k];
                cout_reg[k]  <= add_w[k][CHUNK];
            end
        end
    end
endmodule

// File: tb/tb_mult_cpa_pipe.sv
// Directed and streaming checks for mult_cpa_pipe; carry-save pairs are synthesised from
// a known product p as (r, p - r), standing in for the upstream multiplier.
module tb_mult_cpa_pipe;
    localparam int WIDTH   = 16;
    localparam int CHUNK   = 8;
    localparam int DW      = 2 * WIDTH;
    localparam int NSTAGES = DW / CHUNK;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mult_cpa_pipe_if #(.WIDTH(WIDTH)) bus_if ();

    mult_cpa_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] sprod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [DW-1:0] sa, sb;
        sa = {{WIDTH{a[WIDTH-1]}}, a};
        sb = {{WIDTH{b[WIDTH-1]}}, b};
        return sa * sb;
    endfunction

    // Call at a negedge; returns at the negedge following the accepting edge.
    task automatic push(input logic [DW-1:0] s, input logic [DW-1:0] c, output int stalls);
        bus_if.in_sum   = s;
        bus_if.in_carry = c;
        bus_if.in_valid = 1'b1;
        stalls = 0;
        #2;
        while (!bus_if.in_ready && stalls < 1000) begin
            @(negedge clk);
            #2;
            stalls++;
        end
        @(negedge clk);
    endtask

    task automatic send_and_wait(input string tag, input logic [DW-1:0] s,
                                 input logic [DW-1:0] c, input logic [DW-1:0] expv);
        int st;
        int lat;
        push(s, c, st);
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (!bus_if.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, DW'(lat), DW'(NSTAGES - 1));
        check(tag, bus_if.out_product, expv);
        @(negedge clk);
        check({tag, "_bubble"}, DW'(bus_if.out_valid), '0);
    endtask

    task automatic run_stream(input int n, input bit rand_ready, input string tag);
        int rcv    = 0;
        int cyc    = 0;
        int first  = -1;
        int gaps   = 0;
        int stalls = 0;
        exp_q.delete();
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < n; i++) begin
                    logic [WIDTH-1:0] a, b;
                    logic [DW-1:0]    p, r;
                    int st;
                    a = WIDTH'($urandom);
                    b = WIDTH'($urandom);
                    p = sprod(a, b);
                    r = $urandom;
                    exp_q.push_back(p);
                    push(r, p - r, st);
                    stalls += st;
                end
                bus_if.in_valid = 1'b0;
            end
            begin
                while (rcv < n && cyc < n * 10 + 50) begin
                    @(negedge clk);
                    if (rand_ready) bus_if.out_ready = 1'($urandom_range(0, 1));
                    #1;
                    if (bus_if.out_valid) begin
                        if (first < 0) first = cyc;
                    end else if (first >= 0) begin
                        gaps++;
                    end
                    if (bus_if.out_valid && bus_if.out_ready) begin
                        check({tag, "_spurious"}, DW'(exp_q.size() == 0), '0);
                        if (exp_q.size() > 0) check(tag, bus_if.out_product, exp_q.pop_front());
                        rcv++;
                    end
                    cyc++;
                end
            end
        join
        check({tag, "_count"}, DW'(rcv), DW'(n));
        if (!rand_ready) begin
            check({tag, "_first_valid"}, DW'(first), DW'(NSTAGES));
            check({tag, "_gaps"}, DW'(gaps), '0);
            check({tag, "_in_stalls"}, DW'(stalls), '0);
        end
        bus_if.out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] bp_s [4];
        logic [DW-1:0] bp_c [4];
        logic [DW-1:0] bp_e [4];
        int st;

        bus_if.in_valid  = 1'b0;
        bus_if.in_sum    = '0;
        bus_if.in_carry  = '0;
        bus_if.out_ready = 1'b0;
        reset_n          = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", DW'(bus_if.out_valid), '0);
        check("rst_product", bus_if.out_product, '0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready_empty", DW'(bus_if.in_ready), DW'(1));

        // Carry across a chunk boundary, full ripple with discarded top carry
        bus_if.out_ready = 1'b1;
        send_and_wait("chunk_carry", 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100);
        send_and_wait("full_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        send_and_wait("mid_ripple",  32'h00FF_FF00, 32'h0000_0100, 32'h0100_0000);

        // Signed products delivered as carry-save pairs
        send_and_wait("signed_m3x5", 32'h1234_5678, sprod(16'hFFFD, 16'h0005) - 32'h1234_5678,
                      32'hFFFF_FFF1);
        send_and_wait("signed_min2", 32'hA5A5_0F0F, sprod(16'h8000, 16'h8000) - 32'hA5A5_0F0F,
                      32'h4000_0000);

        // Back-to-back streaming with no backpressure
        run_stream(64, 1'b0, "stream");

        // Fill with four vectors, hold three cycles, then drain
        bp_s = '{32'h0000_00FF, 32'h1234_5678, 32'hFFFF_0000, 32'h8000_0000};
        bp_c = '{32'h0000_0001, 32'h1111_1111, 32'h0001_0000, 32'h8000_0001};
        bp_e = '{32'h0000_0100, 32'h2345_6789, 32'h0000_0000, 32'h0000_0001};
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(bp_s[k], bp_c[k], st);
        bus_if.in_valid = 1'b0;
        for (int h = 0; h < 3; h++) begin
            #1;
            check("bp_in_ready", DW'(bus_if.in_ready), '0);
            check("bp_out_valid", DW'(bus_if.out_valid), DW'(1));
            check("bp_hold_product", bus_if.out_product, bp_e[0]);
            @(negedge clk);
        end
        bus_if.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_drain_valid", DW'(bus_if.out_valid), DW'(1));
            check("bp_drain_product", bus_if.out_product, bp_e[k]);
            @(negedge clk);
        end
        #1;
        check("bp_drained", DW'(bus_if.out_valid), '0);

        // Random backpressure
        run_stream(200, 1'b1, "rand_bp");

        // Reset with three results in flight
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push(bp_s[k], bp_c[k], st);
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        check("rr_pre_valid", DW'(bus_if.out_valid), DW'(1));
        #3;
        reset_n = 1'b0;
        #1;
        check("rr_async_valid", DW'(bus_if.out_valid), '0);
        check("rr_async_product", bus_if.out_product, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        check("rr_post_valid", DW'(bus_if.out_valid), '0);
        send_and_wait("rr_first", 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
